misr_ora: RTL and testbench

//   Output response analyser for the LBIST loop; sits directly downstream of the CUT driven by rpg.
//   - Compacts each CUT response into a multiple-input signature register (MISR).
//   - Ends the session after PATTERNS responses, or on rpg END, whichever comes first.
//   - Compares the final signature against a golden value and reports done/pass.

---
 rtl/lbist_pkg.sv | 33 +++
 rtl/comp.sv | 12 +
 rtl/misr_core.sv | 35 +++
 rtl/misr_ora.sv | 105 ++++++++++
 tb/tb_misr_ora.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/lbist_pkg.sv
// Shared LBIST definitions: FSM encodings, counter width helper
// and the MISR next-state function used by RTL and bench model.
package lbist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int MAX_W = 32;

    function automatic int cnt_w(input int patterns);
        return $clog2(patterns + 1);
    endfunction

    // Right shift with tap feedback into the MSB; bits above 'bits' must be 0.
    function automatic logic [MAX_W-1:0] misr_next(
        input logic [MAX_W-1:0] sig,
        input logic [MAX_W-1:0] resp,
        input logic [MAX_W-1:0] poly,
        input int               bits
    );
        logic [MAX_W-1:0] nxt;
        logic             fb;
        fb  = ^(sig & poly);
        nxt = (sig >> 1) ^ resp;
        nxt[bits-1] = fb ^ resp[bits-1];
        return nxt;
    endfunction

endpackage

// File: rtl/comp.sv
// Equality comparator shared by rpg END detection and the ORA golden check.
module comp #(
    parameter int BITS = 4
) (
    input  logic [BITS-1:0] i_a,
    input  logic [BITS-1:0] i_b,
    output logic            o_eq
);

    assign o_eq = (i_a == i_b);

endmodule

// File: rtl/misr_core.sv
// Multiple-input signature register with seed load and step enable.
module misr_core
    import lbist_pkg::*;
#(
    parameter int            BITS = 4,
    parameter logic [BITS-1:0] POLY = 4'b1001,
    parameter logic [BITS-1:0] SEED = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load_seed,
    input  logic            i_enable,
    input  logic [BITS-1:0] i_resp,
    output logic [BITS-1:0] o_signature
);

    logic [BITS-1:0] r_sig;
    logic [BITS-1:0] w_next;

    assign w_next = BITS'(misr_next(MAX_W'(r_sig), MAX_W'(i_resp),
                                    MAX_W'(POLY), BITS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig <= SEED;
        end else if (i_load_seed) begin
            r_sig <= SEED;
        end else if (i_enable) begin
            r_sig <= w_next;
        end
    end

    assign o_signature = r_sig;

endmodule

// File: rtl/misr_ora.sv
// LBIST output response analyser: MISR compaction, session FSM
// and golden-signature compare.
module misr_ora
    import lbist_pkg::*;
#(
    parameter int              BITS     = 4,
    parameter int              PATTERNS = 15,
    parameter logic [BITS-1:0] POLY     = 4'b1001,
    parameter logic [BITS-1:0] SEED     = 4'b0000,
    parameter logic [BITS-1:0] GOLDEN   = 4'b0000,
    localparam int             CNT_W    = cnt_w(PATTERNS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             rpg_end,
    input  logic             resp_valid,
    input  logic [BITS-1:0]  resp,
    output logic [BITS-1:0]  signature,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    state_e           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    logic w_accept;
    logic w_last;
    logic w_start;
    logic w_eq;

    assign w_accept = (r_state == RUN) && resp_valid;
    assign w_last   = w_accept &&
                      (rpg_end || (r_count == CNT_W'(PATTERNS - 1)));
    assign w_start  = start && ((r_state == IDLE) || (r_state == DONE));

    misr_core #(
        .BITS (BITS),
        .POLY (POLY),
        .SEED (SEED)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .i_load_seed (w_start),
        .i_enable    (w_accept),
        .i_resp      (resp),
        .o_signature (signature)
    );

    comp #(
        .BITS (BITS)
    ) u_golden (
        .i_a  (signature),
        .i_b  (GOLDEN),
        .o_eq (w_eq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_count <= r_count + 1'b1;
                    end
                    if (w_last) begin
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    r_pass  <= w_eq;
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign count = r_count;
    assign busy  = r_busy;
    assign done  = r_done;
    assign pass  = r_pass;

endmodule

// File: tb/tb_misr_ora.sv
// Directed bench for misr_ora: three instances sharing one stimulus
// (PATTERNS=3 with two goldens, PATTERNS=15 for END handling).
module tb_misr_ora;

    logic       clk;
    logic       rst;
    logic       start;
    logic       rpg_end;
    logic       resp_valid;
    logic [3:0] resp;

    logic [3:0] a_sig, b_sig, c_sig;
    logic [1:0] a_cnt, b_cnt;
    logic [3:0] c_cnt;
    logic       a_busy, a_done, a_pass;
    logic       b_busy, b_done, b_pass;
    logic       c_busy, c_done, c_pass;

    int n_checks;
    int n_errors;

    misr_ora #(.BITS(4), .PATTERNS(3), .POLY(4'b1001),
               .SEED(4'b0000), .GOLDEN(4'b1100)) u_a (
        .clk(clk), .rst(rst), .start(start), .rpg_end(rpg_end),
        .resp_valid(resp_valid), .resp(resp), .signature(a_sig),
        .count(a_cnt), .busy(a_busy), .done(a_done), .pass(a_pass)
    );

    misr_ora #(.BITS(4), .PATTERNS(3), .POLY(4'b1001),
               .SEED(4'b0000), .GOLDEN(4'b0110)) u_b (
        .clk(clk), .rst(rst), .start(start), .rpg_end(rpg_end),
        .resp_valid(resp_valid), .resp(resp), .signature(b_sig),
        .count(b_cnt), .busy(b_busy), .done(b_done), .pass(b_pass)
    );

    misr_ora #(.BITS(4), .PATTERNS(15), .POLY(4'b1001),
               .SEED(4'b0000), .GOLDEN(4'b0000)) u_c (
        .clk(clk), .rst(rst), .start(start), .rpg_end(rpg_end),
        .resp_valid(resp_valid), .resp(resp), .signature(c_sig),
        .count(c_cnt), .busy(c_busy), .done(c_done), .pass(c_pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic word(input logic [3:0] r, input logic e);
        resp_valid = 1'b1;
        resp       = r;
        rpg_end    = e;
        tick();
        resp_valid = 1'b0;
        rpg_end    = 1'b0;
        resp       = 4'b0000;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        start      = 1'b0;
        rpg_end    = 1'b0;
        resp_valid = 1'b0;
        resp       = 4'b0000;
        rst        = 1'b1;

        // 1. reset with random inputs
        for (int i = 0; i < 2; i++) begin
            start      = 1'($urandom);
            rpg_end    = 1'($urandom);
            resp_valid = 1'($urandom);
            resp       = 4'($urandom);
            tick();
        end
        chk("rst_sig",  32'(a_sig),  32'h0);
        chk("rst_cnt",  32'(a_cnt),  32'h0);
        chk("rst_busy", 32'(a_busy), 32'h0);
        chk("rst_done", 32'(a_done), 32'h0);
        chk("rst_pass", 32'(a_pass), 32'h0);
        rst = 1'b0; start = 1'b0; rpg_end = 1'b0;
        resp_valid = 1'b0; resp = 4'b0000;
        tick();
        chk("idle_busy", 32'(a_busy), 32'h0);

        // 2/3. back-to-back session, two goldens
        pulse_start();
        chk("t2_busy", 32'(a_busy), 32'h1);
        chk("t2_sig0", 32'(a_sig), 32'h0);
        resp_valid = 1'b1;
        resp = 4'b0001; tick();
        chk("t2_sig1", 32'(a_sig), 32'b0001);
        resp = 4'b0000; tick();
        chk("t2_sig2", 32'(a_sig), 32'b1000);
        tick();
        resp_valid = 1'b0;
        chk("t2_sig3", 32'(a_sig), 32'b1100);
        chk("t2_cnt3", 32'(a_cnt), 32'd3);
        chk("t2_chk_done", 32'(a_done), 32'h0);
        chk("t2_chk_busy", 32'(a_busy), 32'h1);
        tick();
        chk("t2_done", 32'(a_done), 32'h1);
        chk("t2_pass", 32'(a_pass), 32'h1);
        chk("t2_busy_lo", 32'(a_busy), 32'h0);
        chk("t3_done", 32'(b_done), 32'h1);
        chk("t3_pass", 32'(b_pass), 32'h0);
        chk("t3_sig", 32'(b_sig), 32'b1100);
        chk("c_run_cnt", 32'(c_cnt), 32'd3);
        chk("c_run_busy", 32'(c_busy), 32'h1);

        // resp_valid in DONE must not disturb the result
        word(4'b1111, 1'b0);
        chk("done_hold_sig", 32'(a_sig), 32'b1100);
        chk("done_hold_cnt", 32'(a_cnt), 32'd3);
        chk("done_hold_pass", 32'(a_pass), 32'h1);

        // 4. start in DONE re-seeds; gaps between words
        pulse_start();
        chk("t4_sig0", 32'(a_sig), 32'h0);
        chk("t4_cnt0", 32'(a_cnt), 32'd0);
        chk("t4_done_lo", 32'(a_done), 32'h0);
        chk("c_start_ign", 32'(c_cnt), 32'd4);
        word(4'b0001, 1'b0);
        tick(); tick();
        chk("t4_gap1_cnt", 32'(a_cnt), 32'd1);
        chk("t4_gap1_sig", 32'(a_sig), 32'b0001);
        word(4'b0000, 1'b0);
        tick(); tick();
        chk("t4_gap2_cnt", 32'(a_cnt), 32'd2);
        chk("t4_gap2_sig", 32'(a_sig), 32'b1000);
        word(4'b0000, 1'b0);
        tick();
        chk("t4_sig", 32'(a_sig), 32'b1100);
        chk("t4_done", 32'(a_done), 32'h1);
        chk("t4_pass", 32'(a_pass), 32'h1);

        // 5. rpg_end handling on the PATTERNS=15 instance
        pulse_rst();
        pulse_start();
        word(4'b0001, 1'b0);
        rpg_end = 1'b1; tick(); rpg_end = 1'b0;
        chk("t5_end_ign_busy", 32'(c_busy), 32'h1);
        chk("t5_end_ign_cnt", 32'(c_cnt), 32'd1);
        word(4'b0000, 1'b1);
        chk("t5_chk_cnt", 32'(c_cnt), 32'd2);
        chk("t5_chk_sig", 32'(c_sig), 32'b1000);
        chk("t5_chk_done", 32'(c_done), 32'h0);
        tick();
        chk("t5_done", 32'(c_done), 32'h1);
        chk("t5_pass", 32'(c_pass), 32'h0);
        chk("t5_cnt_hold", 32'(c_cnt), 32'd2);

        // 6. mid-RUN reset, start ignored in RUN, restart from DONE
        pulse_start();
        word(4'b0001, 1'b0);
        word(4'b0000, 1'b0);
        chk("t6_cnt2", 32'(c_cnt), 32'd2);
        pulse_rst();
        chk("t6_rst_sig", 32'(c_sig), 32'h0);
        chk("t6_rst_cnt", 32'(c_cnt), 32'd0);
        chk("t6_rst_busy", 32'(c_busy), 32'h0);
        pulse_start();
        word(4'b0001, 1'b0);
        start = 1'b1;
        word(4'b0000, 1'b0);
        start = 1'b0;
        chk("t6_start_ign_cnt", 32'(c_cnt), 32'd2);
        chk("t6_start_ign_sig", 32'(c_sig), 32'b1000);
        word(4'b0000, 1'b1);
        tick();
        chk("t6_done", 32'(c_done), 32'h1);
        chk("t6_sig", 32'(c_sig), 32'b1100);
        pulse_start();
        chk("t6_new_sig", 32'(c_sig), 32'h0);
        chk("t6_new_cnt", 32'(c_cnt), 32'd0);
        chk("t6_new_busy", 32'(c_busy), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
